// File: rtl/cap_channel_router_if.sv
// Bus interface for cap_channel_router.
// Carries the channel payload, the capacitor slot-enable mask and the routed
// capacitor slot outputs. clk and the reset stay plain ports on the router.
//   data_in     : WIDTH*CHANNEL_NUM, channel c at [c*WIDTH +: WIDTH]
//   sw          : CAPACITOR_NUM, bit j enables capacitor slot j
//   data_out_FF : WIDTH*CAPACITOR_NUM, slot j at [j*WIDTH +: WIDTH]
// Modports: master drives data_in/sw, slave (the router) drives data_out_FF.
interface cap_channel_router_if #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned CHANNEL_NUM   = 70,
  parameter int unsigned CAPACITOR_NUM = 128
);

  localparam int unsigned IN_W  = WIDTH * CHANNEL_NUM;
  localparam int unsigned OUT_W = WIDTH * CAPACITOR_NUM;

  logic [IN_W-1:0]          data_in;
  logic [CAPACITOR_NUM-1:0] sw;
  logic [OUT_W-1:0]         data_out_FF;

  modport master (
    output data_in,
    output sw,
    input  data_out_FF
  );

  modport slave (
    input  data_in,
    input  sw,
    output data_out_FF
  );

endinterface : cap_channel_router_if

// File: rtl/cap_channel_router.sv
// cap_channel_router: registered compacting crossbar for the SerDes MUX array.
// The k-th enabled capacitor slot (counting from bit 0 of sw) carries input
// channel k; disabled slots and enabled slots beyond the last channel read 0.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   bus   : cap_channel_router_if.slave (data_in, sw in; data_out_FF out)
// Optional feature macro: ROUTE_INPUT_REG_EN
//   defined   -> data_in/sw registered first, 2-cycle latency
//   undefined -> single output register stage, 1-cycle latency
module cap_channel_router #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned CHANNEL_NUM   = 70,
  parameter int unsigned CAPACITOR_NUM = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cap_channel_router_if.slave   bus
);

  localparam int unsigned IN_W   = WIDTH * CHANNEL_NUM;
  localparam int unsigned OUT_W  = WIDTH * CAPACITOR_NUM;
  localparam int unsigned RANK_W = $clog2(CAPACITOR_NUM + 1);

  logic [IN_W-1:0]          src_data;
  logic [CAPACITOR_NUM-1:0] src_sw;
  logic [OUT_W-1:0]         route_d;
  logic [OUT_W-1:0]         data_out_q;

`ifdef ROUTE_INPUT_REG_EN
  logic [IN_W-1:0]          data_in_q;
  logic [CAPACITOR_NUM-1:0] sw_q;

  // Input capture stage; data and mask move together so no stale mapping.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data_in_q <= '0;
      sw_q      <= '0;
    end else begin
      data_in_q <= bus.data_in;
      sw_q      <= bus.sw;
    end
  end

  assign src_data = data_in_q;
  assign src_sw   = sw_q;
`else
  assign src_data = bus.data_in;
  assign src_sw   = bus.sw;
`endif

  // Compacting route: running enable count gives each slot its channel rank.
  // Ranks at or above CHANNEL_NUM match no channel, so excess slots stay 0.
  always_comb begin : route_comb
    logic [RANK_W-1:0] rank;
    rank    = '0;
    route_d = '0;
    for (int j = 0; j < int'(CAPACITOR_NUM); j++) begin
      if (src_sw[j]) begin
        for (int c = 0; c < int'(CHANNEL_NUM); c++) begin
          if (rank == RANK_W'(c)) begin
            route_d[j*WIDTH +: WIDTH] = src_data[c*WIDTH +: WIDTH];
          end
        end
        rank = rank + RANK_W'(1);
      end
    end
  end

  // Output register directly drives the capacitor DAC/driver stage.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= route_d;
    end
  end

  assign bus.data_out_FF = data_out_q;

endmodule : cap_channel_router

// File: tb/tb_cap_channel_router.sv
// Self-checking bench for cap_channel_router.
// Reference model: list of enabled slot positions, channel k goes to the k-th
// listed slot. Expected outputs are delayed through a latency history that
// follows ROUTE_INPUT_REG_EN (1 or 2 edges).
module tb_cap_channel_router;

  localparam int unsigned W     = 8;
  localparam int unsigned CH    = 70;
  localparam int unsigned CAP   = 128;
  localparam int unsigned IN_W  = W * CH;
  localparam int unsigned OUT_W = W * CAP;
`ifdef ROUTE_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [OUT_W-1:0] hist [LAT];
  logic [OUT_W-1:0] exp_out;

  cap_channel_router_if #(.WIDTH(W), .CHANNEL_NUM(CH), .CAPACITOR_NUM(CAP)) bus ();

  cap_channel_router #(.WIDTH(W), .CHANNEL_NUM(CH), .CAPACITOR_NUM(CAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] din,
                                             input logic [CAP-1:0] s);
    int slots[$];
    logic [OUT_W-1:0] r;
    r = '0;
    for (int j = 0; j < int'(CAP); j++) if (s[j]) slots.push_back(j);
    for (int k = 0; k < slots.size() && k < int'(CH); k++)
      r[slots[k]*W +: W] = din[k*W +: W];
    return r;
  endfunction

  function automatic int first_diff(input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b);
    for (int j = 0; j < int'(CAP); j++) if (a[j*W +: W] !== b[j*W +: W]) return j;
    return 0;
  endfunction

  task automatic check_all(input string tag, input logic [OUT_W-1:0] e);
    int d;
    checks++;
    d = first_diff(bus.data_out_FF, e);
    assert (bus.data_out_FF === e) else begin
      errors++;
      $error("FAIL %s slot %0d observed=%h expected=%h", tag, d,
             bus.data_out_FF[d*W +: W], e[d*W +: W]);
    end
  endtask

  task automatic check_slot(input string tag, input int j, input logic [W-1:0] e);
    checks++;
    assert (bus.data_out_FF[j*W +: W] === e) else begin
      errors++;
      $error("FAIL %s slot %0d observed=%h expected=%h", tag, j, bus.data_out_FF[j*W +: W], e);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < LAT; i++) hist[i] = '0;
  endtask

  // One rising edge; the model is evaluated on the inputs the DUT samples.
  task automatic tick(input string tag);
    logic [OUT_W-1:0] m;
    m = rst_n ? '0 : model(bus.data_in, bus.sw);
    @(posedge clk);
    for (int i = LAT - 1; i > 0; i--) hist[i] = rst_n ? '0 : hist[i-1];
    hist[0] = m;
    exp_out = hist[LAT-1];
    #1;
    check_all(tag, exp_out);
  endtask

  task automatic rand_data();
    for (int c = 0; c < int'(CH); c++) bus.data_in[c*W +: W] = W'($urandom);
  endtask

  function automatic logic [CAP-1:0] rand_sw();
    logic [CAP-1:0] v;
    for (int i = 0; i < int'(CAP) / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    bus.data_in = '0;
    bus.sw = '0;
    clear_hist();

    // 1. held reset with random inputs
    for (int i = 0; i < 4; i++) begin
      rand_data();
      bus.sw = rand_sw();
      tick("reset_hold");
    end
    rst_n = 1'b0;

    // 2. sw[69:0] ones, even channels all-ones
    bus.sw = '0;
    bus.sw[CH-1:0] = '1;
    bus.data_in = '0;
    for (int c = 0; c < int'(CH); c += 2) bus.data_in[c*W +: W] = 8'hFF;
    for (int i = 0; i < LAT; i++) tick("map_even");
    check_slot("map_even_s0", 0, 8'hFF);
    check_slot("map_even_s1", 1, 8'h00);
    check_slot("map_even_s68", 68, 8'hFF);
    check_slot("map_even_s69", 69, 8'h00);
    check_slot("map_even_s70", 70, 8'h00);

    // 3. remap to slots [127:58]
    bus.sw = '0;
    bus.sw[CAP-1:58] = '1;
    for (int i = 0; i < LAT; i++) tick("shift58");
    check_slot("shift58_s57", 57, 8'h00);
    check_slot("shift58_s58", 58, 8'hFF);
    check_slot("shift58_s59", 59, 8'h00);
    check_slot("shift58_s126", 126, 8'hFF);

    // 4. sparse enables {3,10,100}
    bus.sw = '0;
    bus.sw[3] = 1'b1;
    bus.sw[10] = 1'b1;
    bus.sw[100] = 1'b1;
    rand_data();
    bus.data_in[0*W +: W] = 8'h11;
    bus.data_in[1*W +: W] = 8'h22;
    bus.data_in[2*W +: W] = 8'h33;
    for (int i = 0; i < LAT; i++) tick("sparse");
    check_slot("sparse_s3", 3, 8'h11);
    check_slot("sparse_s10", 10, 8'h22);
    check_slot("sparse_s100", 100, 8'h33);
    check_slot("sparse_s0", 0, 8'h00);

    // 5. excess enables: all slots on, all channels 8'hFF
    bus.sw = '1;
    bus.data_in = '1;
    for (int i = 0; i < LAT; i++) tick("excess");
    check_slot("excess_s69", 69, 8'hFF);
    check_slot("excess_s70", 70, 8'h00);
    check_slot("excess_s127", 127, 8'h00);

    // all-zero mask
    bus.sw = '0;
    for (int i = 0; i < LAT; i++) tick("sw_zero");

    // randomized masks of varied density, changing with data every cycle
    for (int i = 0; i < 60; i++) begin
      rand_data();
      case (i % 4)
        0: bus.sw = rand_sw();
        1: bus.sw = rand_sw() & rand_sw() & rand_sw();
        2: bus.sw = rand_sw() | rand_sw();
        default: bus.sw = rand_sw() & rand_sw();
      endcase
      tick("random");
    end

    // reset asserted mid-cycle clears output before the next edge
    rand_data();
    bus.sw = '1;
    tick("pre_reset");
    #2;
    rst_n = 1'b1;
    #1;
    check_all("async_reset", '0);
    clear_hist();
    tick("reset_edge");
    rst_n = 1'b0;

    // resume from current inputs with no history
    for (int i = 0; i < 6; i++) begin
      rand_data();
      bus.sw = rand_sw();
      tick("resume");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cap_channel_router
